register_file_sb: RTL and testbench

REGISTER_FILE_SB -- requirements
Module: register_file_sb

---
 rtl/riscv_pkg.sv | 12 +
 rtl/register_file_sb_if.sv | 35 +++
 rtl/register_file_sb_scoreboard.sv | 45 ++++
 rtl/register_file_sb.sv | 75 +++++++
 tb/tb_register_file_sb.sv | 233 +++++++++++++++++++++++
 5 files changed

// File: rtl/riscv_pkg.sv
// Shared RISC-V core parameters and types: register count, data width,
// register-address width, and the matching address/data typedefs.
package riscv_pkg;

  localparam int XLEN       = 32;
  localparam int REG_COUNT  = 32;
  localparam int REG_ADDR_W = $clog2(REG_COUNT);

  typedef logic [REG_ADDR_W-1:0] reg_addr_t;
  typedef logic [XLEN-1:0]       xlen_t;

endpackage : riscv_pkg

// File: rtl/register_file_sb_if.sv
// Register-file access bundle: one write port, one reserve port, two read ports
// with their busy flags. The master drives addresses and data; the slave answers.
interface register_file_sb_if
  import riscv_pkg::*;
#(
  parameter int XLEN = riscv_pkg::XLEN
);

  // All ports are level-sampled at the rising clock edge; there is no ready
  // back-pressure, so an enable held high for one cycle is exactly one request.
  logic            write_enable;
  reg_addr_t       register_write_select;
  logic [XLEN-1:0] register_data_write;
  logic            reserve_enable;
  reg_addr_t       reserve_select;
  reg_addr_t       rs1;
  reg_addr_t       rs2;
  logic [XLEN-1:0] register_data_1;
  logic [XLEN-1:0] register_data_2;
  logic            rs1_busy;
  logic            rs2_busy;

  modport master (
    output write_enable, register_write_select, register_data_write,
    output reserve_enable, reserve_select, rs1, rs2,
    input  register_data_1, register_data_2, rs1_busy, rs2_busy
  );

  modport slave (
    input  write_enable, register_write_select, register_data_write,
    input  reserve_enable, reserve_select, rs1, rs2,
    output register_data_1, register_data_2, rs1_busy, rs2_busy
  );

endinterface : register_file_sb_if

// File: rtl/register_file_sb_scoreboard.sv
// register_scoreboard: one busy bit per architectural register. Reserve sets,
// a write clears, two combinational query ports; x0 is never busy.
module register_scoreboard
  import riscv_pkg::*;
#(
  parameter int REG_COUNT = riscv_pkg::REG_COUNT
) (
  input  logic      clk_i,
  input  logic      rst_ni,
  input  logic      reserve_en_i,
  input  reg_addr_t reserve_addr_i,
  input  logic      clear_en_i,
  input  reg_addr_t clear_addr_i,
  input  reg_addr_t query1_addr_i,
  input  reg_addr_t query2_addr_i,
  output logic      busy1_o,
  output logic      busy2_o
);

  logic [REG_COUNT-1:0] busy_q;
  logic [REG_COUNT-1:0] busy_d;

  // Set is applied after clear so a same-cycle reserve (new producer) wins.
  always_comb begin
    busy_d = busy_q;
    if (clear_en_i && (clear_addr_i != '0)) begin
      busy_d[clear_addr_i] = 1'b0;
    end
    if (reserve_en_i && (reserve_addr_i != '0)) begin
      busy_d[reserve_addr_i] = 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
    end
  end

  assign busy1_o = (query1_addr_i != '0) && busy_q[query1_addr_i];
  assign busy2_o = (query2_addr_i != '0) && busy_q[query2_addr_i];

endmodule : register_scoreboard

// File: rtl/register_file_sb.sv
// Integer register file with busy-bit scoreboard: two async read ports, one
// write port, x0 hardwired to zero. Define REGFILE_BYPASS_EN for write->read forwarding.
module register_file_sb
  import riscv_pkg::*;
#(
  parameter int XLEN      = riscv_pkg::XLEN,
  parameter int REG_COUNT = riscv_pkg::REG_COUNT
) (
  input  logic                      clock,
  input  logic                      reset,
  register_file_sb_if.slave         bus
);

  logic [XLEN-1:0] regs_q [REG_COUNT];
  logic [XLEN-1:0] regs_d [REG_COUNT];
  logic [XLEN-1:0] stored_1;
  logic [XLEN-1:0] stored_2;
  logic            sb_busy_1;
  logic            sb_busy_2;

  always_comb begin
    regs_d = regs_q;
    if (bus.write_enable && (bus.register_write_select != '0)) begin
      regs_d[bus.register_write_select] = bus.register_data_write;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      regs_q <= '{default: '0};
    end else begin
      regs_q <= regs_d;
    end
  end

  register_scoreboard #(
    .REG_COUNT (REG_COUNT)
  ) u_scoreboard (
    .clk_i          (clock),
    .rst_ni         (reset),
    .reserve_en_i   (bus.reserve_enable),
    .reserve_addr_i (bus.reserve_select),
    .clear_en_i     (bus.write_enable),
    .clear_addr_i   (bus.register_write_select),
    .query1_addr_i  (bus.rs1),
    .query2_addr_i  (bus.rs2),
    .busy1_o        (sb_busy_1),
    .busy2_o        (sb_busy_2)
  );

  assign stored_1 = (bus.rs1 == '0) ? '0 : regs_q[bus.rs1];
  assign stored_2 = (bus.rs2 == '0) ? '0 : regs_q[bus.rs2];

`ifdef REGFILE_BYPASS_EN
  logic fwd_1;
  logic fwd_2;

  // Forwarding is gated by reset so reads stay zero while the file is held clear.
  assign fwd_1 = reset && bus.write_enable && (bus.rs1 != '0)
              && (bus.rs1 == bus.register_write_select);
  assign fwd_2 = reset && bus.write_enable && (bus.rs2 != '0)
              && (bus.rs2 == bus.register_write_select);

  assign bus.register_data_1 = fwd_1 ? bus.register_data_write : stored_1;
  assign bus.register_data_2 = fwd_2 ? bus.register_data_write : stored_2;
  assign bus.rs1_busy        = sb_busy_1 && !fwd_1;
  assign bus.rs2_busy        = sb_busy_2 && !fwd_2;
`else
  assign bus.register_data_1 = stored_1;
  assign bus.register_data_2 = stored_2;
  assign bus.rs1_busy        = sb_busy_1;
  assign bus.rs2_busy        = sb_busy_2;
`endif

endmodule : register_file_sb

// File: tb/tb_register_file_sb.sv
// Directed bench for register_file_sb: storage sweep, x0 rules, scoreboard
// reserve/clear, same-cycle reserve+write, bypass behaviour and async reset.
module tb_register_file_sb;
  import riscv_pkg::*;

  logic clock;
  logic reset;
  int   n_assert;
  int   n_fail;

  register_file_sb_if #(.XLEN(32)) bus ();

  register_file_sb #(
    .XLEN      (32),
    .REG_COUNT (32)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_inputs();
    bus.write_enable          = 1'b0;
    bus.register_write_select = '0;
    bus.register_data_write   = '0;
    bus.reserve_enable        = 1'b0;
    bus.reserve_select        = '0;
  endtask

  initial begin
    n_assert = 0;
    n_fail   = 0;
    reset    = 1'b0;
    idle_inputs();
    bus.rs1 = 5'd5;
    bus.rs2 = 5'd9;

    // Reset state
    #12;
    chk("reset_data1", bus.register_data_1, 32'h0);
    chk("reset_data2", bus.register_data_2, 32'h0);
    chk("reset_busy1", {31'd0, bus.rs1_busy}, 32'h0);
    chk("reset_busy2", {31'd0, bus.rs2_busy}, 32'h0);
    @(negedge clock);
    reset = 1'b1;
    tick();

    // Fill x1..x31 with i, then sweep both read ports
    for (int i = 1; i < 32; i++) begin
      bus.write_enable          = 1'b1;
      bus.register_write_select = 5'(i);
      bus.register_data_write   = 32'(i);
      tick();
    end
    idle_inputs();
    for (int a = 0; a < 32; a++) begin
      bus.rs1 = 5'(a);
      bus.rs2 = 5'(a);
      #1;
      chk($sformatf("sweep_rs1_%0d", a), bus.register_data_1, 32'(a));
      chk($sformatf("sweep_rs2_%0d", a), bus.register_data_2, 32'(a));
    end

    // x0 ignores writes and reserves
    bus.write_enable          = 1'b1;
    bus.register_write_select = 5'd0;
    bus.register_data_write   = 32'hDEADBEEF;
    bus.reserve_enable        = 1'b1;
    bus.reserve_select        = 5'd0;
    tick();
    idle_inputs();
    bus.rs1 = 5'd0;
    #1;
    chk("x0_data", bus.register_data_1, 32'h0);
    chk("x0_busy", {31'd0, bus.rs1_busy}, 32'h0);

    // Reserve x5, then clear it with a write
    bus.reserve_enable = 1'b1;
    bus.reserve_select = 5'd5;
    tick();
    idle_inputs();
    bus.rs1 = 5'd5;
    #1;
    chk("x5_reserved_busy", {31'd0, bus.rs1_busy}, 32'h1);
    chk("x5_reserved_data", bus.register_data_1, 32'd5);
    bus.write_enable          = 1'b1;
    bus.register_write_select = 5'd5;
    bus.register_data_write   = 32'h12345678;
    #1;
`ifdef REGFILE_BYPASS_EN
    chk("x5_wcycle_data", bus.register_data_1, 32'h12345678);
    chk("x5_wcycle_busy", {31'd0, bus.rs1_busy}, 32'h0);
`else
    chk("x5_wcycle_data", bus.register_data_1, 32'd5);
    chk("x5_wcycle_busy", {31'd0, bus.rs1_busy}, 32'h1);
`endif
    tick();
    idle_inputs();
    #1;
    chk("x5_cleared_busy", {31'd0, bus.rs1_busy}, 32'h0);
    chk("x5_written_data", bus.register_data_1, 32'h12345678);

    // Same-cycle reserve and write of x7: data lands, busy stays set
    bus.rs2                   = 5'd7;
    bus.write_enable          = 1'b1;
    bus.register_write_select = 5'd7;
    bus.register_data_write   = 32'hCAFE0007;
    bus.reserve_enable        = 1'b1;
    bus.reserve_select        = 5'd7;
    tick();
    idle_inputs();
    #1;
    chk("x7_both_data", bus.register_data_2, 32'hCAFE0007);
    chk("x7_both_busy", {31'd0, bus.rs2_busy}, 32'h1);
    bus.write_enable          = 1'b1;
    bus.register_write_select = 5'd7;
    bus.register_data_write   = 32'h00000077;
    tick();
    idle_inputs();
    #1;
    chk("x7_clear_busy", {31'd0, bus.rs2_busy}, 32'h0);
    chk("x7_clear_data", bus.register_data_2, 32'h00000077);

    // Write to a register that is not busy
    bus.rs2                   = 5'd8;
    bus.write_enable          = 1'b1;
    bus.register_write_select = 5'd8;
    bus.register_data_write   = 32'h0BAD0008;
    tick();
    idle_inputs();
    #1;
    chk("x8_notbusy_busy", {31'd0, bus.rs2_busy}, 32'h0);
    chk("x8_notbusy_data", bus.register_data_2, 32'h0BAD0008);

    // Write x3 while both ports read it
    bus.rs1                   = 5'd3;
    bus.rs2                   = 5'd3;
    bus.write_enable          = 1'b1;
    bus.register_write_select = 5'd3;
    bus.register_data_write   = 32'hA5A5A5A5;
    #1;
`ifdef REGFILE_BYPASS_EN
    chk("x3_wcycle_data1", bus.register_data_1, 32'hA5A5A5A5);
    chk("x3_wcycle_data2", bus.register_data_2, 32'hA5A5A5A5);
`else
    chk("x3_wcycle_data1", bus.register_data_1, 32'd3);
    chk("x3_wcycle_data2", bus.register_data_2, 32'd3);
`endif
    tick();
    bus.write_enable        = 1'b0;
    bus.register_data_write = 32'h11111111;
    #1;
    chk("x3_next_data1", bus.register_data_1, 32'hA5A5A5A5);
    chk("x3_next_data2", bus.register_data_2, 32'hA5A5A5A5);
    tick();
    tick();
    chk("x3_hold_data", bus.register_data_1, 32'hA5A5A5A5);
    idle_inputs();

    // x9 = 0x55 and busy, then reset mid-cycle
    bus.rs1                   = 5'd9;
    bus.rs2                   = 5'd9;
    bus.write_enable          = 1'b1;
    bus.register_write_select = 5'd9;
    bus.register_data_write   = 32'h55;
    bus.reserve_enable        = 1'b1;
    bus.reserve_select        = 5'd9;
    tick();
    idle_inputs();
    #1;
    chk("x9_pre_data", bus.register_data_1, 32'h55);
    chk("x9_pre_busy", {31'd0, bus.rs1_busy}, 32'h1);
    #1;
    reset = 1'b0;
    #1;
    chk("async_rst_data1", bus.register_data_1, 32'h0);
    chk("async_rst_data2", bus.register_data_2, 32'h0);
    chk("async_rst_busy1", {31'd0, bus.rs1_busy}, 32'h0);
    chk("async_rst_busy2", {31'd0, bus.rs2_busy}, 32'h0);

    // Requests during reset are discarded
    bus.rs1                   = 5'd10;
    bus.write_enable          = 1'b1;
    bus.register_write_select = 5'd10;
    bus.register_data_write   = 32'hFFFF0010;
    bus.reserve_enable        = 1'b1;
    bus.reserve_select        = 5'd10;
    #1;
    chk("in_rst_data", bus.register_data_1, 32'h0);
    tick();
    tick();
    idle_inputs();
    reset = 1'b1;
    #1;
    chk("post_rst_x10_data", bus.register_data_1, 32'h0);
    chk("post_rst_x10_busy", {31'd0, bus.rs1_busy}, 32'h0);

    // First edge after reset release accepts a write
    bus.rs1                   = 5'd11;
    bus.write_enable          = 1'b1;
    bus.register_write_select = 5'd11;
    bus.register_data_write   = 32'h000000BB;
    tick();
    idle_inputs();
    #1;
    chk("first_write_x11", bus.register_data_1, 32'h000000BB);
    bus.rs1 = 5'd3;
    #1;
    chk("post_rst_x3_cleared", bus.register_data_1, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule : tb_register_file_sb
